gpio_in_filter: RTL and testbench
=================================

Name: gpio_in_filter

Overview:
- Sits directly downstream of the pad control stage in the safe domain and consumes its gpio input vector.
- Per bit, it synchronises the asynchronous pad input, debounces it with a programmable cycle count and detects edges on the filtered level.
- Detected edges are latched as sticky pending flags that drive one level interrupt toward the SoC event unit.

Parameters:
- N_IN, 32: number of gpio inputs filtered.
- CNT_W, 8: width of the debounce counter and of the threshold input.

Ports:
- clk_i  input  1  block clock.
- rst_i  input  1  synchronous reset, active-high.
- gpio_in_i  input  N_IN  raw gpio inputs from pad control; asynchronous to clk_i.
- en_i  input  N_IN  per-bit filter enable.
- deb_cycles_i  input  CNT_W  debounce threshold D, shared by all bits; quasi-static.
- irq_type_i  input  N_IN x 2  per-bit event type: 00 none, 01 rising, 10 falling, 11 both.
- irq_mask_i  input  N_IN  per-bit interrupt enable.
- clr_valid_i  input  1  pending-clear strobe.
- clr_mask_i  input  N_IN  bits to clear when clr_valid_i=1.
- gpio_filt_o  output  N_IN  debounced level per bit.
- pending_o  output  N_IN  sticky edge flags.
- irq_o  output  1  OR over (pending_o AND irq_mask_i), registered.

Behaviour:
- All state is updated on the rising edge of clk_i.
- When rst_i=1: sync flops, gpio_filt_o, counters, pending_o and irq_o are all 0.
- Synchroniser: 2-flop per bit (s1, s2). A pin change sampled at edge k appears on s2 at edge k+1.
- Debounce, per bit with en_i=1, applied in this priority order:
  - if s2==filt: cnt<=0.
  - else if cnt==D: filt<=s2 and cnt<=0.
  - else: cnt<=cnt+1.
- Timing of a clean level change: gpio_filt_o updates at edge k+D+2.
- D=0: filt follows s2 one cycle later, with no filtering.
- Glitches shorter than D+1 cycles at s2 reset cnt and never reach filt.
- The counter never exceeds D, so it cannot wrap.
- en_i=0: cnt held at 0, filt frozen at its current value, no edge detected. The sync flops keep running.
- Edge detect: a registered copy filt_q. The edge fires in the cycle where filt != filt_q.
  - rise = filt & ~filt_q; fall = ~filt & filt_q.
  - qualified by irq_type_i.
- Pending bit per bit:
  - set by a qualified edge.
  - cleared when clr_valid_i & clr_mask_i[b].
  - simultaneous set and clear: set wins, so no event is lost.
  - irq_type_i=00 never sets the bit; an already-set bit is kept.
- Timing of pending and interrupt: pending_o rises at edge k+D+4. irq_o follows one cycle after the pending bit or mask change.
- Changing deb_cycles_i below a running cnt: the next cycle compares cnt>=D and treats it as reached, so the level is accepted.

Optional Feature:
- Macro: GPIO_IN_FILTER_GLITCH_CNT_EN.
- When defined:
  - extra output glitch_cnt_o (16 bits).
  - counts, over all bits, the cycles in which a bit's non-zero cnt is reset because s2 returned to filt.
  - saturates at 0xFFFF.
  - cleared by rst_i, or by clr_valid_i with clr_mask_i all ones.
- When undefined: the port and the counter do not exist. All other behaviour is identical.

Decomposition:
- Package gpio_in_filter_pkg:
  - enum irq_type_e {IRQ_NONE, IRQ_RISE, IRQ_FALL, IRQ_BOTH} on 2 bits.
  - localparam GLITCH_CNT_W=16.
- Sub-module gpio_in_filter_bit: synchroniser, debounce counter, filt/filt_q, rise/fall outputs.
  - Instantiated N_IN times in a generate loop.
  - Pending, clear, irq and glitch aggregation stay in the top.

Test Plan:
- Reset: hold rst_i=1 for 3 cycles with gpio_in_i=all ones. Required: all outputs 0. After release with D=4, gpio_filt_o = all ones at edge 6 after release.
- Debounce reject: D=4, bit3 pulsed high for 4 cycles. Required: gpio_filt_o[3] stays 0 and pending_o stays 0. Under GPIO_IN_FILTER_GLITCH_CNT_EN, glitch_cnt_o increments by 1.
- Debounce accept and edge type: D=4, bit3 held high 5+ cycles, irq_type=01, mask=1. Required: pending_o[3]=1 at edge k+8 and irq_o=1 at k+9. The later fall does not set pending again.
- Clear versus set collision: irq_type=11. Assert clr_valid_i with clr_mask_i[5]=1 in the same cycle bit5's filtered edge fires. Required: pending_o[5] stays 1. A clear one cycle later drops it, and irq_o follows.
- Enable gating and D=0: en_i[7]=0 while the pin toggles. Required: no change on gpio_filt_o[7] and no pending. With en_i[7]=1 and D=0, filt follows the pin with 3-cycle latency.
- Reset mid-operation: assert rst_i while cnt=2 of D=4 and pending is set. Required: everything returns to 0 on the next edge. No spurious edge after release when the pin is 0.

Source files
------------

// File: rtl/gpio_in_filter_pkg.sv
// Shared types and constants for the gpio input filter.
package gpio_in_filter_pkg;

  typedef enum logic [1:0] {
    IRQ_NONE = 2'b00,
    IRQ_RISE = 2'b01,
    IRQ_FALL = 2'b10,
    IRQ_BOTH = 2'b11
  } irq_type_e;

  localparam int GLITCH_CNT_W = 16;

endpackage

// File: rtl/gpio_in_filter_if.sv
// Bus bundle between the gpio filter and its control/pad side.
// glitch_cnt_o exists only with GPIO_IN_FILTER_GLITCH_CNT_EN defined.
interface gpio_in_filter_if #(
  parameter int N_IN  = 32,
  parameter int CNT_W = 8
);
  import gpio_in_filter_pkg::*;

  logic [N_IN-1:0]       gpio_in_i;
  logic [N_IN-1:0]       en_i;
  logic [CNT_W-1:0]      deb_cycles_i;
  logic [N_IN-1:0][1:0]  irq_type_i;
  logic [N_IN-1:0]       irq_mask_i;
  logic                  clr_valid_i;
  logic [N_IN-1:0]       clr_mask_i;
  logic [N_IN-1:0]       gpio_filt_o;
  logic [N_IN-1:0]       pending_o;
  logic                  irq_o;
`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt_o;
`endif

  modport master (
    output gpio_in_i, en_i, deb_cycles_i, irq_type_i, irq_mask_i, clr_valid_i, clr_mask_i,
    input  gpio_filt_o, pending_o, irq_o
`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
    , input glitch_cnt_o
`endif
  );

  modport slave (
    input  gpio_in_i, en_i, deb_cycles_i, irq_type_i, irq_mask_i, clr_valid_i, clr_mask_i,
    output gpio_filt_o, pending_o, irq_o
`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
    , output glitch_cnt_o
`endif
  );

endinterface

// File: rtl/gpio_in_filter_bit.sv
// One gpio lane: 2-flop synchroniser, debounce counter, filtered level and
// registered rise/fall strobes (one cycle after the filtered level changes).
module gpio_in_filter_bit #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pin,
  input  logic             en,
  input  logic [CNT_W-1:0] deb_cycles,
  output logic             filt,
  output logic             rise,
  output logic             fall,
  output logic             glitch
);

  logic             s1, s2, filt_q;
  logic [CNT_W-1:0] cnt;

  // A pulse that dies while the counter is running is a rejected glitch.
  assign glitch = en && (s2 == filt) && (cnt != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      filt   <= 1'b0;
      filt_q <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1     <= pin;
      s2     <= s1;
      filt_q <= filt;
      rise   <= en & filt & ~filt_q;
      fall   <= en & ~filt & filt_q;
      if (!en || (s2 == filt)) begin
        cnt <= '0;
      end else if (cnt >= deb_cycles) begin
        // >= so a threshold lowered under a running count still accepts
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input filter: per-bit sync/debounce lanes, sticky edge pending flags
// and one level irq. Optional glitch counter under GPIO_IN_FILTER_GLITCH_CNT_EN.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int N_IN  = 32,
  parameter int CNT_W = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  gpio_in_filter_if.slave bus
);

  logic [N_IN-1:0] filt, rise, fall, glitch, set_v, clr_v, pending;
  logic            irq;

  for (genvar g = 0; g < N_IN; g++) begin : g_lane
    gpio_in_filter_bit #(.CNT_W(CNT_W)) u_bit (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pin        (bus.gpio_in_i[g]),
      .en         (bus.en_i[g]),
      .deb_cycles (bus.deb_cycles_i),
      .filt       (filt[g]),
      .rise       (rise[g]),
      .fall       (fall[g]),
      .glitch     (glitch[g])
    );
  end

  always_comb begin
    set_v = '0;
    for (int b = 0; b < N_IN; b++) begin
      case (irq_type_e'(bus.irq_type_i[b]))
        IRQ_RISE: set_v[b] = rise[b];
        IRQ_FALL: set_v[b] = fall[b];
        IRQ_BOTH: set_v[b] = rise[b] | fall[b];
        default:  set_v[b] = 1'b0;
      endcase
    end
  end

  assign clr_v = bus.clr_valid_i ? bus.clr_mask_i : '0;

  // Set is OR-ed after the clear so a colliding edge is never lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= (pending & ~clr_v) | set_v;
      irq     <= |(pending & bus.irq_mask_i);
    end
  end

  assign bus.gpio_filt_o = filt;
  assign bus.pending_o   = pending;
  assign bus.irq_o       = irq;

`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt;
  logic [GLITCH_CNT_W:0]   glitch_sum;

  assign glitch_sum = {1'b0, glitch_cnt} + (GLITCH_CNT_W+1)'($countones(glitch));

  always_ff @(posedge clk_i) begin
    if (rst_i || (bus.clr_valid_i && (&bus.clr_mask_i))) begin
      glitch_cnt <= '0;
    end else if (glitch_sum[GLITCH_CNT_W]) begin
      glitch_cnt <= '1;
    end else begin
      glitch_cnt <= glitch_sum[GLITCH_CNT_W-1:0];
    end
  end

  assign bus.glitch_cnt_o = glitch_cnt;
`else
  logic glitch_unused;
  assign glitch_unused = |glitch;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter; inputs driven and outputs sampled 1ns after posedge.
module tb_gpio_in_filter;
  import gpio_in_filter_pkg::*;

  localparam int N_IN  = 32;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gpio_in_filter_if #(.N_IN(N_IN), .CNT_W(CNT_W)) ifc ();

  gpio_in_filter #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    ifc.clr_valid_i = 1'b1;
    ifc.clr_mask_i  = '1;
    tick(1);
    ifc.clr_valid_i = 1'b0;
    ifc.clr_mask_i  = '0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.gpio_in_i    = '1;
    ifc.en_i         = '1;
    ifc.deb_cycles_i = 8'd4;
    ifc.irq_type_i   = '0;
    ifc.irq_mask_i   = '0;
    ifc.clr_valid_i  = 1'b0;
    ifc.clr_mask_i   = '0;
    tick(3);
    checks++;
    if (ifc.gpio_filt_o !== '0 || ifc.pending_o !== '0 || ifc.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs filt=%h pend=%h irq=%b want 0", ifc.gpio_filt_o, ifc.pending_o, ifc.irq_o);
    end
`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
    checks++;
    if (ifc.glitch_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_glitch got=%0d want 0", ifc.glitch_cnt_o);
    end
`endif
    // first edge with rst low is edge 0; level lands on edge 6
    rst = 1'b0;
    tick(6);
    checks++;
    if (ifc.gpio_filt_o !== '0) begin
      errors++;
      $display("FAIL release_early filt=%h want 0", ifc.gpio_filt_o);
    end
    tick(1);
    checks++;
    if (ifc.gpio_filt_o !== '1) begin
      errors++;
      $display("FAIL release_filt filt=%h want ffffffff", ifc.gpio_filt_o);
    end
    ifc.gpio_in_i = '0;
    tick(10);
    checks++;
    if (ifc.gpio_filt_o !== '0 || ifc.pending_o !== '0) begin
      errors++;
      $display("FAIL type_none filt=%h pend=%h want 0 0", ifc.gpio_filt_o, ifc.pending_o);
    end
  endtask

  task automatic test_debounce_reject();
    logic saw_filt = 1'b0;
    logic saw_pend = 1'b0;
    ifc.irq_type_i[3] = IRQ_RISE;
    ifc.irq_mask_i[3] = 1'b1;
    ifc.gpio_in_i[3]  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      saw_filt |= ifc.gpio_filt_o[3];
      saw_pend |= ifc.pending_o[3];
    end
    ifc.gpio_in_i[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      saw_filt |= ifc.gpio_filt_o[3];
      saw_pend |= ifc.pending_o[3];
    end
    checks++;
    if (saw_filt !== 1'b0 || saw_pend !== 1'b0) begin
      errors++;
      $display("FAIL reject4 filt_seen=%b pend_seen=%b want 0 0", saw_filt, saw_pend);
    end
`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
    checks++;
    if (ifc.glitch_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL glitch_inc got=%0d want 1", ifc.glitch_cnt_o);
    end
    clear_all();
    checks++;
    if (ifc.glitch_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL glitch_clr got=%0d want 0", ifc.glitch_cnt_o);
    end
`endif
  endtask

  task automatic test_debounce_accept();
    ifc.gpio_in_i[3] = 1'b1;
    tick(7);
    checks++;
    if (ifc.gpio_filt_o[3] !== 1'b1 || ifc.pending_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL accept_k6 filt=%b pend=%b want 1 0", ifc.gpio_filt_o[3], ifc.pending_o[3]);
    end
    tick(1);
    checks++;
    if (ifc.pending_o[3] !== 1'b0) begin
      errors++;
      $display("FAIL pend_k7 got=%b want 0", ifc.pending_o[3]);
    end
    tick(1);
    checks++;
    if (ifc.pending_o[3] !== 1'b1 || ifc.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL pend_k8 pend=%b irq=%b want 1 0", ifc.pending_o[3], ifc.irq_o);
    end
    tick(1);
    checks++;
    if (ifc.irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_k9 got=%b want 1", ifc.irq_o);
    end
    clear_all();
    ifc.gpio_in_i[3] = 1'b0;
    tick(12);
    checks++;
    if (ifc.gpio_filt_o[3] !== 1'b0 || ifc.pending_o[3] !== 1'b0 || ifc.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL fall_ignored filt=%b pend=%b irq=%b want 0 0 0",
               ifc.gpio_filt_o[3], ifc.pending_o[3], ifc.irq_o);
    end
  endtask

  task automatic test_clear_collision();
    ifc.irq_type_i[5] = IRQ_BOTH;
    ifc.irq_mask_i[5] = 1'b1;
    ifc.gpio_in_i[5]  = 1'b1;
    tick(8);
    // set and clear hit pending[5] on the same edge
    ifc.clr_valid_i = 1'b1;
    ifc.clr_mask_i  = 32'h1 << 5;
    tick(1);
    checks++;
    if (ifc.pending_o[5] !== 1'b1) begin
      errors++;
      $display("FAIL collide_set got=%b want 1", ifc.pending_o[5]);
    end
    tick(1);
    checks++;
    if (ifc.pending_o[5] !== 1'b0 || ifc.irq_o !== 1'b1) begin
      errors++;
      $display("FAIL late_clear pend=%b irq=%b want 0 1", ifc.pending_o[5], ifc.irq_o);
    end
    ifc.clr_valid_i = 1'b0;
    ifc.clr_mask_i  = '0;
    tick(1);
    checks++;
    if (ifc.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_drop got=%b want 0", ifc.irq_o);
    end
    ifc.gpio_in_i[5] = 1'b0;
    tick(10);
    checks++;
    if (ifc.pending_o[5] !== 1'b1) begin
      errors++;
      $display("FAIL both_fall got=%b want 1", ifc.pending_o[5]);
    end
    clear_all();
  endtask

  task automatic test_enable_d0();
    logic saw_filt = 1'b0;
    logic saw_pend = 1'b0;
    ifc.en_i[7]       = 1'b0;
    ifc.irq_type_i[7] = IRQ_BOTH;
    ifc.irq_mask_i[7] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ifc.gpio_in_i[7] = (i < 10) || (i >= 13 && i < 21);
      tick(1);
      saw_filt |= ifc.gpio_filt_o[7];
      saw_pend |= ifc.pending_o[7];
    end
    ifc.gpio_in_i[7] = 1'b0;
    tick(4);
    checks++;
    if (saw_filt !== 1'b0 || saw_pend !== 1'b0) begin
      errors++;
      $display("FAIL en_gate filt_seen=%b pend_seen=%b want 0 0", saw_filt, saw_pend);
    end
    ifc.en_i[7]      = 1'b1;
    ifc.deb_cycles_i = 8'd0;
    tick(3);
    ifc.gpio_in_i[7] = 1'b1;
    tick(2);
    checks++;
    if (ifc.gpio_filt_o[7] !== 1'b0) begin
      errors++;
      $display("FAIL d0_rise_early got=%b want 0", ifc.gpio_filt_o[7]);
    end
    tick(1);
    checks++;
    if (ifc.gpio_filt_o[7] !== 1'b1) begin
      errors++;
      $display("FAIL d0_rise got=%b want 1", ifc.gpio_filt_o[7]);
    end
    ifc.gpio_in_i[7] = 1'b0;
    tick(2);
    checks++;
    if (ifc.gpio_filt_o[7] !== 1'b1) begin
      errors++;
      $display("FAIL d0_fall_early got=%b want 1", ifc.gpio_filt_o[7]);
    end
    tick(1);
    checks++;
    if (ifc.gpio_filt_o[7] !== 1'b0) begin
      errors++;
      $display("FAIL d0_fall got=%b want 0", ifc.gpio_filt_o[7]);
    end
    ifc.deb_cycles_i = 8'd4;
    tick(3);
    clear_all();
  endtask

  task automatic test_reset_mid();
    logic saw_any = 1'b0;
    ifc.irq_type_i[3] = IRQ_RISE;
    ifc.irq_mask_i[3] = 1'b1;
    ifc.gpio_in_i[3]  = 1'b1;
    tick(10);
    checks++;
    if (ifc.pending_o[3] !== 1'b1 || ifc.irq_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre pend=%b irq=%b want 1 1", ifc.pending_o[3], ifc.irq_o);
    end
    ifc.gpio_in_i[9] = 1'b1;
    tick(4);
    rst = 1'b1;
    ifc.gpio_in_i = '0;
    tick(1);
    checks++;
    if (ifc.gpio_filt_o !== '0 || ifc.pending_o !== '0 || ifc.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset filt=%h pend=%h irq=%b want 0", ifc.gpio_filt_o, ifc.pending_o, ifc.irq_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      saw_any |= (|ifc.gpio_filt_o) | (|ifc.pending_o) | ifc.irq_o;
    end
    checks++;
    if (saw_any !== 1'b0) begin
      errors++;
      $display("FAIL post_release activity=%b want 0", saw_any);
    end
`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
    checks++;
    if (ifc.glitch_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL mid_glitch got=%0d want 0", ifc.glitch_cnt_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_debounce_reject();
    test_debounce_accept();
    test_clear_collision();
    test_enable_d0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
